// File: rtl/serial_compare_ctrl.sv
// -----------------------------------------------------------------------------
// serial_compare_ctrl
//
// Performs a WIDTH-bit magnitude compare by stepping the operand bits MSB-first
// through one external, combinational, cascadable 1-bit comparator slice. The
// cascade state (gt/eq/lt) is carried in registers between steps. Signed
// compares swap the operand bits on the MSB step only. With EARLY_EXIT=1 the
// walk stops on the first differing bit.
//
// Parameters
//   WIDTH       operand width in bits (>= 2)
//   EARLY_EXIT  1 = finish on the first unequal bit, 0 = always step WIDTH bits
//   CW          width of res_bits, derived from WIDTH
//
// Ports
//   clk, rst_n                 rising-edge clock, synchronous active-low reset
//   start_valid / start_ready  command handshake (ready only while idle)
//   op_a, op_b, is_signed      command payload, sampled at acceptance
//   slc_a, slc_b               bit pair presented to the slice
//   slc_gt_in/eq_in/lt_in      cascade inputs presented to the slice
//   slc_gt, slc_eq, slc_lt     slice cascade outputs (same-cycle combinational)
//   res_valid / res_ready      result handshake (valid held until taken)
//   res_gt, res_eq, res_lt     one-hot result: A>B, A==B, A<B
//   res_bits                   number of bit steps performed (1..WIDTH)
// -----------------------------------------------------------------------------
module serial_compare_ctrl #(
  parameter  int WIDTH      = 32,
  parameter  int EARLY_EXIT = 1,
  localparam int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             is_signed,

  output logic             slc_a,
  output logic             slc_b,
  output logic             slc_gt_in,
  output logic             slc_eq_in,
  output logic             slc_lt_in,
  input  logic             slc_gt,
  input  logic             slc_eq,
  input  logic             slc_lt,

  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_gt,
  output logic             res_eq,
  output logic             res_lt,
  output logic [CW-1:0]    res_bits
);

  localparam int         IW  = $clog2(WIDTH);
  localparam logic [IW-1:0] MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    steps_q;

  // Cascade registers; they feed the slice cascade inputs directly.
  logic gt_q;
  logic eq_q;
  logic lt_q;

  // Slice bit pair is registered: it is loaded with the bits for the step
  // about to run, so the slice sees glitch-free flop outputs.
  logic slc_a_q;
  logic slc_b_q;

  logic          res_gt_q;
  logic          res_eq_q;
  logic          res_lt_q;
  logic [CW-1:0] res_bits_q;

  logic          accept;
  logic          step_last;
  logic [IW-1:0] idx_dec;

  assign accept    = (state == IDLE) && start_valid;
  assign idx_dec   = idx_q - IW'(1);
  // The walk ends at bit 0, or as soon as the slice reports a difference
  // when early exit is enabled.
  assign step_last = (idx_q == '0) || ((EARLY_EXIT != 0) && !slc_eq);

  // NOTE: the operand registers carry no reset; they are only read while in
  // RUN, which can only be entered through an accept that loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= op_a;
      b_q <= op_b;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every branch
  // sees the pre-edge value of the registers it reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx_q      <= MSB;
      steps_q    <= '0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b1;
      lt_q       <= 1'b0;
      slc_a_q    <= 1'b0;
      slc_b_q    <= 1'b0;
      res_gt_q   <= 1'b0;
      res_eq_q   <= 1'b0;
      res_lt_q   <= 1'b0;
      res_bits_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            idx_q   <= MSB;
            steps_q <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            // Signed compare swaps the sign bits, so a negative A against a
            // non-negative B resolves as "less than".
            slc_a_q <= is_signed ? op_b[WIDTH-1] : op_a[WIDTH-1];
            slc_b_q <= is_signed ? op_a[WIDTH-1] : op_b[WIDTH-1];
            state   <= RUN;
          end
        end

        RUN: begin
          if (step_last) begin
            res_gt_q   <= slc_gt;
            res_eq_q   <= slc_eq;
            res_lt_q   <= slc_lt;
            res_bits_q <= steps_q + CW'(1);
            // Return the slice interface to its idle pattern while the
            // result waits to be taken.
            idx_q      <= MSB;
            steps_q    <= '0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b1;
            lt_q       <= 1'b0;
            slc_a_q    <= 1'b0;
            slc_b_q    <= 1'b0;
            state      <= DONE;
          end else begin
            gt_q    <= slc_gt;
            eq_q    <= slc_eq;
            lt_q    <= slc_lt;
            steps_q <= steps_q + CW'(1);
            idx_q   <= idx_dec;
            // Steps below the MSB are never swapped.
            slc_a_q <= a_q[idx_dec];
            slc_b_q <= b_q[idx_dec];
          end
        end

        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);

  assign slc_a     = slc_a_q;
  assign slc_b     = slc_b_q;
  assign slc_gt_in = gt_q;
  assign slc_eq_in = eq_q;
  assign slc_lt_in = lt_q;

  assign res_gt   = res_gt_q;
  assign res_eq   = res_eq_q;
  assign res_lt   = res_lt_q;
  assign res_bits = res_bits_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_compare_ctrl
//
// Two controllers are instantiated: index 0 with EARLY_EXIT=1, index 1 with
// EARLY_EXIT=0. Each has its own model of the 1-bit cascadable slice. Results
// are predicted from plain signed/unsigned integer comparison and the position
// of the highest differing bit.
// -----------------------------------------------------------------------------
module tb_serial_compare_ctrl;

  localparam int W  = 32;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          start_valid [2];
  logic          start_ready [2];
  logic [W-1:0]  op_a        [2];
  logic [W-1:0]  op_b        [2];
  logic          is_signed   [2];
  logic          slc_a       [2];
  logic          slc_b       [2];
  logic          slc_gt_in   [2];
  logic          slc_eq_in   [2];
  logic          slc_lt_in   [2];
  logic          slc_gt      [2];
  logic          slc_eq      [2];
  logic          slc_lt      [2];
  logic          res_valid   [2];
  logic          res_ready   [2];
  logic          res_gt      [2];
  logic          res_eq      [2];
  logic          res_lt      [2];
  logic [CW-1:0] res_bits    [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    serial_compare_ctrl #(
      .WIDTH      (W),
      .EARLY_EXIT ((g == 0) ? 1 : 0)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid[g]),
      .start_ready (start_ready[g]),
      .op_a        (op_a[g]),
      .op_b        (op_b[g]),
      .is_signed   (is_signed[g]),
      .slc_a       (slc_a[g]),
      .slc_b       (slc_b[g]),
      .slc_gt_in   (slc_gt_in[g]),
      .slc_eq_in   (slc_eq_in[g]),
      .slc_lt_in   (slc_lt_in[g]),
      .slc_gt      (slc_gt[g]),
      .slc_eq      (slc_eq[g]),
      .slc_lt      (slc_lt[g]),
      .res_valid   (res_valid[g]),
      .res_ready   (res_ready[g]),
      .res_gt      (res_gt[g]),
      .res_eq      (res_eq[g]),
      .res_lt      (res_lt[g]),
      .res_bits    (res_bits[g])
    );

    // Combinational comparator slice.
    assign slc_gt[g] = slc_gt_in[g] | (slc_a[g] & ~slc_b[g] & slc_eq_in[g]);
    assign slc_eq[g] = ~(slc_a[g] ^ slc_b[g]) & slc_eq_in[g];
    assign slc_lt[g] = slc_lt_in[g] | (~slc_a[g] & slc_b[g] & slc_eq_in[g]);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer compare plus step count from the highest differing bit.
  task automatic ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         input bit early, output bit gt, output bit eq, output bit lt,
                         output int k);
    longint va, vb;
    int h;
    va = s ? longint'({{32{a[W-1]}}, a}) : longint'({32'b0, a});
    vb = s ? longint'({{32{b[W-1]}}, b}) : longint'({32'b0, b});
    gt = (va > vb);
    eq = (va == vb);
    lt = (va < vb);
    h = -1;
    for (int i = W - 1; i >= 0; i--) begin
      if (h < 0 && a[i] != b[i]) h = i;
    end
    k = (!early || h < 0) ? W : (W - h);
  endtask

  task automatic check_reset(input int g);
    check($sformatf("d%0d rst start_ready", g), 64'(start_ready[g]), 64'd1);
    check($sformatf("d%0d rst res_valid", g), 64'(res_valid[g]), 64'd0);
    check($sformatf("d%0d rst res_gt", g), 64'(res_gt[g]), 64'd0);
    check($sformatf("d%0d rst res_eq", g), 64'(res_eq[g]), 64'd0);
    check($sformatf("d%0d rst res_lt", g), 64'(res_lt[g]), 64'd0);
    check($sformatf("d%0d rst res_bits", g), 64'(res_bits[g]), 64'd0);
    check($sformatf("d%0d rst slc_a", g), 64'(slc_a[g]), 64'd0);
    check($sformatf("d%0d rst slc_b", g), 64'(slc_b[g]), 64'd0);
    check($sformatf("d%0d rst slc_gt_in", g), 64'(slc_gt_in[g]), 64'd0);
    check($sformatf("d%0d rst slc_eq_in", g), 64'(slc_eq_in[g]), 64'd1);
    check($sformatf("d%0d rst slc_lt_in", g), 64'(slc_lt_in[g]), 64'd0);
  endtask

  // One full command: accept, per-step slice checks, result, optional
  // backpressure for 'hold' cycles, then release back to idle.
  task automatic run_cmd(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit s, input int hold);
    bit egt, eeq, elt;
    int k;
    logic [63:0] ua, ub;
    ref_cmp(a, b, s, (g == 0), egt, eeq, elt, k);
    ua = {32'b0, a};
    ub = {32'b0, b};
    @(negedge clk);
    check($sformatf("d%0d idle start_ready", g), 64'(start_ready[g]), 64'd1);
    start_valid[g] = 1'b1;
    op_a[g]        = a;
    op_b[g]        = b;
    is_signed[g]   = s;
    @(negedge clk);
    for (int st = 1; st <= k; st++) begin
      int idx;
      idx = W - st;
      // Operands and stray handshakes after acceptance must have no effect.
      start_valid[g] = 1'($urandom);
      op_a[g]        = $urandom;
      op_b[g]        = $urandom;
      is_signed[g]   = 1'($urandom);
      res_ready[g]   = 1'($urandom);
      check($sformatf("d%0d s%0d start_ready", g, st), 64'(start_ready[g]), 64'd0);
      check($sformatf("d%0d s%0d res_valid", g, st), 64'(res_valid[g]), 64'd0);
      check($sformatf("d%0d s%0d slc_a", g, st), 64'(slc_a[g]),
            64'((s && idx == W - 1) ? b[idx] : a[idx]));
      check($sformatf("d%0d s%0d slc_b", g, st), 64'(slc_b[g]),
            64'((s && idx == W - 1) ? a[idx] : b[idx]));
      check($sformatf("d%0d s%0d slc_eq_in", g, st), 64'(slc_eq_in[g]),
            64'((ua >> (idx + 1)) == (ub >> (idx + 1))));
      @(negedge clk);
    end
    check($sformatf("d%0d res_valid", g), 64'(res_valid[g]), 64'd1);
    check($sformatf("d%0d res_gt", g), 64'(res_gt[g]), 64'(egt));
    check($sformatf("d%0d res_eq", g), 64'(res_eq[g]), 64'(eeq));
    check($sformatf("d%0d res_lt", g), 64'(res_lt[g]), 64'(elt));
    check($sformatf("d%0d res_bits", g), 64'(res_bits[g]), 64'(k));
    check($sformatf("d%0d done start_ready", g), 64'(start_ready[g]), 64'd0);
    for (int h = 0; h < hold; h++) begin
      res_ready[g]   = 1'b0;
      start_valid[g] = 1'b1;
      op_a[g]        = $urandom;
      op_b[g]        = $urandom;
      @(negedge clk);
      check($sformatf("d%0d hold%0d res_valid", g, h), 64'(res_valid[g]), 64'd1);
      check($sformatf("d%0d hold%0d res_gt", g, h), 64'(res_gt[g]), 64'(egt));
      check($sformatf("d%0d hold%0d res_eq", g, h), 64'(res_eq[g]), 64'(eeq));
      check($sformatf("d%0d hold%0d res_lt", g, h), 64'(res_lt[g]), 64'(elt));
      check($sformatf("d%0d hold%0d res_bits", g, h), 64'(res_bits[g]), 64'(k));
      check($sformatf("d%0d hold%0d start_ready", g, h), 64'(start_ready[g]), 64'd0);
    end
    start_valid[g] = 1'b0;
    res_ready[g]   = 1'b1;
    @(negedge clk);
    check($sformatf("d%0d release start_ready", g), 64'(start_ready[g]), 64'd1);
    check($sformatf("d%0d release res_valid", g), 64'(res_valid[g]), 64'd0);
    res_ready[g] = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra;
    for (int g = 0; g < 2; g++) begin
      start_valid[g] = 1'b0;
      op_a[g]        = '0;
      op_b[g]        = '0;
      is_signed[g]   = 1'b0;
      res_ready[g]   = 1'b0;
    end

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;

    // Directed cases.
    run_cmd(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
    run_cmd(0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 0);
    run_cmd(0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 0);
    run_cmd(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    run_cmd(1, 32'h00000002, 32'h00000003, 1'b0, 0);
    run_cmd(1, 32'h80000000, 32'h00000001, 1'b1, 0);
    run_cmd(0, 32'h12345678, 32'h12345670, 1'b0, 10);

    // Reset in the middle of a walk, then a normal command.
    ra = $urandom;
    @(negedge clk);
    start_valid[0] = 1'b1;
    op_a[0]        = ra;
    op_b[0]        = ra;
    is_signed[0]   = 1'b0;
    @(negedge clk);
    start_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    run_cmd(0, 32'h0000FFFF, 32'h0001FFFF, 1'b0, 0);

    // Randomized commands across both controllers.
    for (int i = 0; i < 60; i++) begin
      int g;
      int pat;
      logic [W-1:0] a, b;
      bit s;
      g   = i % 2;
      pat = int'($urandom_range(0, 3));
      s   = 1'($urandom);
      a   = $urandom;
      case (pat)
        0:       b = $urandom;
        1:       b = a;
        2:       b = a ^ (32'h1 << $urandom_range(0, W - 1));
        default: begin
          a = a | 32'h80000000;
          b = $urandom & 32'h7FFFFFFF;
        end
      endcase
      run_cmd(g, a, b, s, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
